match_req_dispatch: RTL
=======================

// Module: match_req_dispatch
// PURPOSE
//  Fans a lazy-match request group (up to L slots, strobed) out over C match-PE request channels, tagging each request with its slot index.
//  Arms match_resp_sync for the group, then holds off the next group until that group's responses have been consumed.
//  Sits between job_pe (group source) and the match_pe array; it is the request-side peer of match_resp_sync.
// PARAMETERS
//  L         `LAZY_LEN           slots per request group
//  C         `NUM_MATCH_REQ_CH   match request channels (C <= L)
//  TAG_BITS  `LAZY_LEN_LOG2      tag width = slot index width
//  PW        32                  per-slot request payload width (history address etc.)
// PORTS
//  clk                 in   1         clock
//  rst_n               in   1         asynchronous active-low reset
//  grp_in_valid        in   1         request group offered by job_pe
//  grp_in_ready        out  1         group accepted when valid&ready
//  grp_in_strb         in   L         slot i carries a live request
//  grp_in_payload      in   L*PW      slot i payload at [i*PW +: PW]
//  req_valid           out  C         channel c request valid
//  req_ready           in   C         channel c accepts request
//  req_tag             out  C*TAG_BITS slot index of channel c request
//  req_payload         out  C*PW      payload of channel c request
//  sync_group_valid    out  1         one-cycle arm pulse to match_resp_sync
//  sync_group_strb     out  L         strobe copied from accepted group
//  resp_group_done     in   1         resp_group_valid & resp_group_ready from match_resp_sync
// BEHAVIOUR
//  Reset: async clear; all outputs 0 except grp_in_ready=1 (state IDLE); pending mask, output regs, payload store 0.
//  FSM: IDLE -> DISPATCH on grp_in_valid (or -> WAIT_RESP when grp_in_strb==0); DISPATCH -> WAIT_RESP when
//   pending==0 and no req_valid left un-handshaken; WAIT_RESP -> IDLE on resp_group_done. grp_in_ready = (state==IDLE).
//  Accept cycle T: latch strb into pending mask and sync_group_strb, latch all payloads. T+1: sync_group_valid=1 for exactly one cycle.
//  Slot-to-channel binding static: slot i -> channel i % C. Each channel serves its pending slots in ascending index order.
//  Per-channel output register: loads when empty or when req_valid&req_ready this cycle. It takes the lowest pending slot
//   bound to that channel and clears its pending bit in the same cycle. First req_valid at T+1, same cycle as the sync pulse.
//   With ready held high, a channel issues one request per cycle.
//  req_valid held until handshake; req_tag/req_payload stable while valid&~ready. Channels are independent; one channel
//   stalling never blocks another.
//  Tag = slot index i, TAG_BITS wide. Payload = stored grp_in_payload slot i, unmodified.
//  Match PEs respond >=1 cycle after request handshake, so the sync pulse always precedes any response.
//  Empty group (strb==0): no req_valid; sync pulse still issued with strb 0; wait in WAIT_RESP for resp_group_done.
//  resp_group_done outside WAIT_RESP: ignored. New group offered in same cycle WAIT_RESP->IDLE: not accepted until next cycle.
//  Reset mid-operation: in-flight requests dropped, outputs zero immediately (async). match_resp_sync is reset by the same rst_n.
// STRUCTURE
//  parameters.vh: LAZY_LEN, LAZY_LEN_LOG2, NUM_MATCH_REQ_CH (existing); add MATCH_REQ_PAYLOAD_BITS for PW.
//  State encodings (IDLE/DISPATCH/WAIT_RESP) are localparams in this file.
//  Sub-module match_req_chan (one per channel, generate loop): takes the pending mask restricted to its slots, does
//   priority pick + output register, returns clear-bit vector. Top does FSM, payload store, pending-mask OR-reduce of clears.
// TESTING  (L=4, C=2, PW=32, payload slot i = 0x100+i unless noted)
//  1 strb=1111, all ready -> ch0 tags 0,2 at T+1,T+2; ch1 tags 1,3 at T+1,T+2; sync pulse strb 1111 at T+1; WAIT_RESP at T+3.
//  2 strb=0101 -> ch0 tag0 (0x100) T+1, tag2 (0x102) T+2; ch1 req_valid never asserted.
//  3 strb=0000 -> no req_valid; sync pulse strb 0 at T+1; grp_in_ready low until resp_group_done, then high next cycle.
//  4 strb=1111, req_ready[0]=0 for cycles T+1..T+3 -> ch0 holds tag0/0x100 stable; ch1 finishes tags 1,3; ch0 tag2 follows the handshake.
//  5 second group offered in the resp_group_done cycle -> not accepted; accepted the following cycle, new sync pulse 1 cycle later.
//  6 rst_n low mid-DISPATCH -> req_valid, sync_group_valid=0 asynchronously; after release grp_in_ready=1, pending cleared.

Source files
------------

// File: rtl/match_req_dispatch_pkg.sv
// Shared definitions for the match request dispatcher.
//   LAZY_LEN / LAZY_LEN_LOG2 / NUM_MATCH_REQ_CH / MATCH_REQ_PAYLOAD_BITS
//     default values for L, TAG_BITS, C and PW
//   state_e            dispatcher FSM states
//   chan_slot_mask()   slots statically bound to a channel (slot i -> channel i % C)
package match_req_dispatch_pkg;

  localparam int unsigned LAZY_LEN               = 4;
  localparam int unsigned LAZY_LEN_LOG2          = 2;
  localparam int unsigned NUM_MATCH_REQ_CH       = 2;
  localparam int unsigned MATCH_REQ_PAYLOAD_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT_RESP
  } state_e;

  // Bit i set when slot i is served by channel ch (l <= 32).
  function automatic logic [31:0] chan_slot_mask(input int unsigned l,
                                                 input int unsigned c,
                                                 input int unsigned ch);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < l; i++) begin
      if ((i % c) == ch) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/match_req_chan.sv
// One match request channel: picks the lowest pending slot bound to this
// channel and holds it in an output register until handshaken.
//   clk, rst_n       clock, async active-low reset
//   pend             pending slot mask (all slots; this channel uses its own)
//   payload_src      per-slot payloads, slot i at [i*PW +: PW]
//   req_ready        downstream accepts the request
//   req_valid/tag/payload  registered request
//   clr              one-hot slot taken this cycle (to clear its pending bit)
module match_req_chan
  import match_req_dispatch_pkg::*;
#(
  parameter int unsigned L        = LAZY_LEN,
  parameter int unsigned C        = NUM_MATCH_REQ_CH,
  parameter int unsigned CH       = 0,
  parameter int unsigned TAG_BITS = LAZY_LEN_LOG2,
  parameter int unsigned PW       = MATCH_REQ_PAYLOAD_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [L-1:0]        pend,
  input  logic [L*PW-1:0]     payload_src,
  input  logic                req_ready,
  output logic                req_valid,
  output logic [TAG_BITS-1:0] req_tag,
  output logic [PW-1:0]       req_payload,
  output logic [L-1:0]        clr
);

  localparam logic [L-1:0] MASK = L'(chan_slot_mask(L, C, CH));

  logic                valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [PW-1:0]       payload_q, payload_d;
  logic [L-1:0]        pend_m;
  logic                found;
  int unsigned         pick;

  always_comb begin
    pend_m    = pend & MASK;
    found     = 1'b0;
    pick      = 0;
    clr       = '0;
    valid_d   = valid_q;
    tag_d     = tag_q;
    payload_d = payload_q;
    for (int unsigned i = 0; i < L; i++) begin
      if (!found && pend_m[i]) begin
        found = 1'b1;
        pick  = i;
      end
    end
    // Register is free when empty or being handshaken this cycle.
    if (!valid_q || req_ready) begin
      valid_d = found;
      if (found) begin
        tag_d     = TAG_BITS'(pick);
        payload_d = PW'(payload_src >> (pick * PW));
        clr       = L'(1) << pick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      tag_q     <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      payload_q <= payload_d;
    end
  end

  assign req_valid   = valid_q;
  assign req_tag     = tag_q;
  assign req_payload = payload_q;

endmodule

// File: rtl/match_req_dispatch.sv
// Fans a strobed lazy-match request group out over C request channels,
// tagging each request with its slot index, arms match_resp_sync with a
// one-cycle pulse, and holds off the next group until responses are consumed.
//   clk, rst_n          clock, async active-low reset
//   grp_in_*            group from job_pe (valid/ready, L-bit strobe, L*PW payload)
//   req_*               C request channels to the match PEs (valid/ready/tag/payload)
//   sync_group_*        arm pulse and strobe to match_resp_sync
//   resp_group_done     response group consumed
module match_req_dispatch
  import match_req_dispatch_pkg::*;
#(
  parameter int unsigned L        = LAZY_LEN,
  parameter int unsigned C        = NUM_MATCH_REQ_CH,
  parameter int unsigned TAG_BITS = LAZY_LEN_LOG2,
  parameter int unsigned PW       = MATCH_REQ_PAYLOAD_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  grp_in_valid,
  output logic                  grp_in_ready,
  input  logic [L-1:0]          grp_in_strb,
  input  logic [L*PW-1:0]       grp_in_payload,
  output logic [C-1:0]          req_valid,
  input  logic [C-1:0]          req_ready,
  output logic [C*TAG_BITS-1:0] req_tag,
  output logic [C*PW-1:0]       req_payload,
  output logic                  sync_group_valid,
  output logic [L-1:0]          sync_group_strb,
  input  logic                  resp_group_done
);

  state_e          state_q, state_d;
  logic            accept;
  logic            all_issued;
  logic [L-1:0]    pending_q, pending_d;
  logic [L-1:0]    pend_src;
  logic [L-1:0]    clr_all;
  logic [L-1:0]    chan_clr [C];
  logic [L*PW-1:0] store_q, store_d;
  logic [L*PW-1:0] pay_src;
  logic            sync_valid_q, sync_valid_d;
  logic [L-1:0]    sync_strb_q, sync_strb_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (grp_in_valid)
                      state_d = (grp_in_strb == '0) ? ST_WAIT_RESP : ST_DISPATCH;
      ST_DISPATCH:  if (all_issued) state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: if (resp_group_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    grp_in_ready = (state_q == ST_IDLE);
    accept       = grp_in_ready & grp_in_valid;
  end

  // Channels pick straight from the incoming group in the accept cycle so
  // the first requests appear together with the sync pulse.
  always_comb begin
    pend_src = accept ? grp_in_strb : pending_q;
    pay_src  = accept ? grp_in_payload : store_q;
    clr_all  = '0;
    for (int unsigned c = 0; c < C; c++) clr_all = clr_all | chan_clr[c];
    pending_d    = pend_src & ~clr_all;
    store_d      = pay_src;
    sync_valid_d = accept;
    sync_strb_d  = accept ? grp_in_strb : sync_strb_q;
    all_issued   = (pending_q == '0) && ((req_valid & ~req_ready) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      store_q      <= '0;
      sync_valid_q <= 1'b0;
      sync_strb_q  <= '0;
    end else begin
      pending_q    <= pending_d;
      store_q      <= store_d;
      sync_valid_q <= sync_valid_d;
      sync_strb_q  <= sync_strb_d;
    end
  end

  assign sync_group_valid = sync_valid_q;
  assign sync_group_strb  = sync_strb_q;

  for (genvar c = 0; c < C; c++) begin : g_chan
    match_req_chan #(
      .L        (L),
      .C        (C),
      .CH       (c),
      .TAG_BITS (TAG_BITS),
      .PW       (PW)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .pend        (pend_src),
      .payload_src (pay_src),
      .req_ready   (req_ready[c]),
      .req_valid   (req_valid[c]),
      .req_tag     (req_tag[c*TAG_BITS +: TAG_BITS]),
      .req_payload (req_payload[c*PW +: PW]),
      .clr         (chan_clr[c])
    );
  end

endmodule
